// File: rtl/bsram_access_unit.sv
// bsram_access_unit
//   Initiator-side access unit between a core memory stage and a word-wide
//   BSRAM with a same-cycle read port. Accepts byte/half/word loads and
//   stores over a valid/ready handshake. Loads return lane-extracted,
//   sign- or zero-extended data one cycle after accept. Word stores write
//   directly. Sub-word stores read the target word in the accept cycle and
//   write the merged word in the following (MERGE) cycle.
//
// Ports
//   clock, reset            sole clock; synchronous active-high reset
//   reqValid/reqReady       request handshake
//   reqWrite, reqSize,      request kind, size (00 B, 01 H, 10 W, 11 illegal),
//   reqSigned               load extension mode
//   reqAddress              byte address, ADDR_WIDTH+2 bits
//   reqWriteData            right-aligned store data
//   rspValid/rspData/       one-cycle response pulse, load data (0 for stores
//   rspError                and errors), misaligned/illegal flag
//   memRead*/memWrite*      BSRAM read/write ports (word addresses)
//   report                  debug request; this synthesizable view keeps no
//                           printing logic, the input is accepted and ignored
module bsram_access_unit #(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [1:0]            reqSize,
    input  logic                  reqSigned,
    input  logic [ADDR_WIDTH+1:0] reqAddress,
    input  logic [31:0]           reqWriteData,
    output logic                  rspValid,
    output logic [31:0]           rspData,
    output logic                  rspError,
    output logic                  memReadEnable,
    output logic [ADDR_WIDTH-1:0] memReadAddress,
    input  logic [31:0]           memReadData,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memWriteAddress,
    output logic [31:0]           memWriteData,
    input  logic                  report
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MERGE = 1'b1
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                state_q, state_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [1:0]            lat_lane_q, lat_lane_d;
    logic                  lat_half_q, lat_half_d;
    logic [15:0]           lat_data_q, lat_data_d;
    logic [31:0]           lat_word_q, lat_word_d;

    logic [ADDR_WIDTH-1:0] req_waddr;
    logic [1:0]            req_lane;
    logic                  req_err;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           load_data;
    logic [31:0]           merge_word;

    // Debug input has no hardware effect here.
    logic unused_report;
    assign unused_report = report;

    assign req_waddr = reqAddress[ADDR_WIDTH+1:2];
    assign req_lane  = reqAddress[1:0];

    assign req_err = (reqSize == 2'b11)
                   || ((reqSize == SZ_HALF) && req_lane[0])
                   || ((reqSize == SZ_WORD) && (req_lane != 2'b00));

    // Lane extraction from the same-cycle read data.
    assign ld_byte = memReadData[{req_lane, 3'b000} +: 8];
    assign ld_half = memReadData[{req_lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data = memReadData;
        case (reqSize)
            SZ_BYTE: load_data = reqSigned ? {{24{ld_byte[7]}}, ld_byte}
                                           : {24'h0, ld_byte};
            SZ_HALF: load_data = reqSigned ? {{16{ld_half[15]}}, ld_half}
                                           : {16'h0, ld_half};
            default: load_data = memReadData;
        endcase
    end

    // Replace the latched lane inside the word captured at accept time.
    always_comb begin
        merge_word = lat_word_q;
        if (lat_half_q) begin
            merge_word[{lat_lane_q[1], 4'b0000} +: 16] = lat_data_q;
        end else begin
            merge_word[{lat_lane_q, 3'b000} +: 8] = lat_data_q[7:0];
        end
    end

    always_comb begin
        state_d         = state_q;
        rsp_valid_d     = 1'b0;
        rsp_data_d      = 32'h0;
        rsp_error_d     = 1'b0;
        lat_addr_d      = lat_addr_q;
        lat_lane_d      = lat_lane_q;
        lat_half_d      = lat_half_q;
        lat_data_d      = lat_data_q;
        lat_word_d      = lat_word_q;
        reqReady        = 1'b0;
        memReadEnable   = 1'b0;
        memReadAddress  = '0;
        memWriteEnable  = 1'b0;
        memWriteAddress = '0;
        memWriteData    = 32'h0;

        // Reset gates every handshake and memory strobe; a pending merge
        // is simply abandoned.
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    reqReady = 1'b1;
                    if (reqValid) begin
                        if (req_err) begin
                            rsp_valid_d = 1'b1;
                            rsp_error_d = 1'b1;
                        end else if (!reqWrite) begin
                            memReadEnable  = 1'b1;
                            memReadAddress = req_waddr;
                            rsp_valid_d    = 1'b1;
                            rsp_data_d     = load_data;
                        end else if (reqSize == SZ_WORD) begin
                            memWriteEnable  = 1'b1;
                            memWriteAddress = req_waddr;
                            memWriteData    = reqWriteData;
                            rsp_valid_d     = 1'b1;
                        end else begin
                            // Sub-word store: read now, write next cycle.
                            memReadEnable  = 1'b1;
                            memReadAddress = req_waddr;
                            lat_addr_d     = req_waddr;
                            lat_lane_d     = req_lane;
                            lat_half_d     = (reqSize == SZ_HALF);
                            lat_data_d     = reqWriteData[15:0];
                            lat_word_d     = memReadData;
                            state_d        = S_MERGE;
                        end
                    end
                end
                S_MERGE: begin
                    memWriteEnable  = 1'b1;
                    memWriteAddress = lat_addr_q;
                    memWriteData    = merge_word;
                    rsp_valid_d     = 1'b1;
                    state_d         = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_error_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_lane_q  <= 2'b00;
            lat_half_q  <= 1'b0;
            lat_data_q  <= 16'h0;
            lat_word_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            lat_addr_q  <= lat_addr_d;
            lat_lane_q  <= lat_lane_d;
            lat_half_q  <= lat_half_d;
            lat_data_q  <= lat_data_d;
            lat_word_q  <= lat_word_d;
        end
    end

    assign rspValid = rsp_valid_q;
    assign rspData  = rsp_data_q;
    assign rspError = rsp_error_q;

endmodule

// File: tb/tb_bsram_access_unit.sv
// Self-checking bench for bsram_access_unit: a behavioural same-cycle-read
// BSRAM, a table of single-request vectors with hand-computed results, and
// hand-written sequences for back-to-back traffic and reset during MERGE.
module tb_bsram_access_unit;

    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          reqValid;
    logic          reqReady;
    logic          reqWrite;
    logic [1:0]    reqSize;
    logic          reqSigned;
    logic [AW+1:0] reqAddress;
    logic [31:0]   reqWriteData;
    logic          rspValid;
    logic [31:0]   rspData;
    logic          rspError;
    logic          memReadEnable;
    logic [AW-1:0] memReadAddress;
    logic [31:0]   memReadData;
    logic          memWriteEnable;
    logic [AW-1:0] memWriteAddress;
    logic [31:0]   memWriteData;
    logic          report;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    bsram_access_unit #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqWrite       (reqWrite),
        .reqSize        (reqSize),
        .reqSigned      (reqSigned),
        .reqAddress     (reqAddress),
        .reqWriteData   (reqWriteData),
        .rspValid       (rspValid),
        .rspData        (rspData),
        .rspError       (rspError),
        .memReadEnable  (memReadEnable),
        .memReadAddress (memReadAddress),
        .memReadData    (memReadData),
        .memWriteEnable (memWriteEnable),
        .memWriteAddress(memWriteAddress),
        .memWriteData   (memWriteData),
        .report         (report)
    );

    // Behavioural BSRAM: combinational read, write on posedge.
    logic [31:0] mem [0:(1<<AW)-1];
    assign memReadData = mem[memReadAddress];
    always @(posedge clock) begin
        if (memWriteEnable) mem[memWriteAddress] <= memWriteData;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [AW+1:0] a, input logic [31:0] wd);
        reqValid     = 1'b1;
        reqWrite     = wr;
        reqSize      = sz;
        reqSigned    = sg;
        reqAddress   = a;
        reqWriteData = wd;
    endtask

    task automatic idle_req();
        reqValid     = 1'b0;
        reqWrite     = 1'b0;
        reqSize      = 2'b00;
        reqSigned    = 1'b0;
        reqAddress   = '0;
        reqWriteData = 32'h0;
    endtask

    typedef struct {
        logic          wr;
        logic [1:0]    sz;
        logic          sg;
        logic [AW+1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_data;
        logic          exp_err;
        logic [31:0]   exp_mw;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic wr, logic [1:0] sz, logic sg, logic [AW+1:0] a,
                                logic [31:0] wd, logic [31:0] ed, logic ee, logic [31:0] mw);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sg = sg; v.addr = a; v.wdata = wd;
        v.exp_data = ed; v.exp_err = ee; v.exp_mw = mw;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        report = 1'b0;
        idle_req();
        reset = 1'b1;

        //           wr  sz    sg   addr    wdata         exp_data      err   exp mem write
        vecs.push_back(mk(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b10, 0, 10'h010, 32'h0,        32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 10'h004, 32'h11223344, 32'h0,        0, 32'h11223344));
        vecs.push_back(mk(1, 2'b00, 0, 10'h005, 32'h000000A5, 32'h0,        0, 32'h1122A544));
        vecs.push_back(mk(0, 2'b10, 0, 10'h004, 32'h0,        32'h1122A544, 0, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 10'h000, 32'h80FF0000, 32'h0,        0, 32'h80FF0000));
        vecs.push_back(mk(0, 2'b00, 1, 10'h003, 32'h0,        32'hFFFFFF80, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 0, 10'h003, 32'h0,        32'h00000080, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 1, 10'h002, 32'h0,        32'hFFFF80FF, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 10'h000, 32'h0,        32'h00000000, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 10'h002, 32'h0,        32'hFFFFFFFF, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 10'h002, 32'h0,        32'h000080FF, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 1, 10'h000, 32'h0,        32'h80FF0000, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 10'h001, 32'h0,        32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 10'h002, 32'h12345678, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 2'b11, 0, 10'h000, 32'h0,        32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 2'b11, 0, 10'h004, 32'hCAFEF00D, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 10'h000, 32'h0,        32'h80FF0000, 0, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 10'h006, 32'hFFFF7777, 32'h0,        0, 32'h7777A544));
        vecs.push_back(mk(1, 2'b00, 0, 10'h007, 32'h123456CC, 32'h0,        0, 32'hCC77A544));
        vecs.push_back(mk(0, 2'b00, 1, 10'h007, 32'h0,        32'hFFFFFFCC, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 10'h004, 32'h0,        32'hCC77A544, 0, 32'h0));

        // Reset state: strobes forced low while reset is high.
        repeat (2) @(negedge clock);
        reqValid = 1'b1;
        #1;
        chk("rst_ready",  {31'h0, reqReady},       32'h0);
        chk("rst_rd_en",  {31'h0, memReadEnable},  32'h0);
        chk("rst_wr_en",  {31'h0, memWriteEnable}, 32'h0);
        reqValid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'h0, rspValid}, 32'h0);
        chk("rst_rsp_data",  rspData,           32'h0);
        chk("rst_rsp_error", {31'h0, rspError}, 32'h0);
        chk("rst_ready_post",{31'h0, reqReady}, 32'h1);

        // Table-driven single requests.
        foreach (vecs[i]) begin
            vec_t v;
            logic sub;
            v   = vecs[i];
            sub = v.wr && !v.exp_err && (v.sz != 2'b10);
            @(negedge clock);
            drive(v.wr, v.sz, v.sg, v.addr, v.wdata);
            #1;
            chk($sformatf("v%0d_ready", i), {31'h0, reqReady}, 32'h1);
            if (v.exp_err) begin
                chk($sformatf("v%0d_rd_en", i), {31'h0, memReadEnable},  32'h0);
                chk($sformatf("v%0d_wr_en", i), {31'h0, memWriteEnable}, 32'h0);
            end else if (!v.wr || sub) begin
                chk($sformatf("v%0d_rd_en", i),   {31'h0, memReadEnable},  32'h1);
                chk($sformatf("v%0d_wr_en", i),   {31'h0, memWriteEnable}, 32'h0);
                chk($sformatf("v%0d_rd_addr", i), {24'h0, memReadAddress}, {24'h0, v.addr[AW+1:2]});
            end else begin
                chk($sformatf("v%0d_rd_en", i),   {31'h0, memReadEnable},   32'h0);
                chk($sformatf("v%0d_wr_en", i),   {31'h0, memWriteEnable},  32'h1);
                chk($sformatf("v%0d_wr_addr", i), {24'h0, memWriteAddress}, {24'h0, v.addr[AW+1:2]});
                chk($sformatf("v%0d_wr_data", i), memWriteData, v.exp_mw);
            end
            @(negedge clock);
            idle_req();
            #1;
            if (sub) begin
                chk($sformatf("v%0d_merge_ready", i), {31'h0, reqReady},        32'h0);
                chk($sformatf("v%0d_merge_rd_en", i), {31'h0, memReadEnable},   32'h0);
                chk($sformatf("v%0d_merge_wr_en", i), {31'h0, memWriteEnable},  32'h1);
                chk($sformatf("v%0d_merge_addr", i),  {24'h0, memWriteAddress}, {24'h0, v.addr[AW+1:2]});
                chk($sformatf("v%0d_merge_data", i),  memWriteData, v.exp_mw);
                chk($sformatf("v%0d_merge_rspv", i),  {31'h0, rspValid},        32'h0);
                @(negedge clock);
                #1;
            end
            chk($sformatf("v%0d_rsp_valid", i), {31'h0, rspValid}, 32'h1);
            chk($sformatf("v%0d_rsp_data", i),  rspData, v.exp_data);
            chk($sformatf("v%0d_rsp_error", i), {31'h0, rspError}, {31'h0, v.exp_err});
        end

        // Idle cycle: no response due.
        @(negedge clock);
        #1;
        chk("idle_rsp_valid", {31'h0, rspValid}, 32'h0);

        // Four back-to-back loads: continuous rspValid.
        begin
            logic [AW+1:0] ba [4];
            logic [31:0]   be [4];
            ba[0] = 10'h010; be[0] = 32'hDEADBEEF;
            ba[1] = 10'h004; be[1] = 32'hCC77A544;
            ba[2] = 10'h000; be[2] = 32'h80FF0000;
            ba[3] = 10'h010; be[3] = 32'hDEADBEEF;
            for (int k = 0; k < 5; k++) begin
                @(negedge clock);
                if (k > 0) begin
                    #1;
                    chk($sformatf("b2b%0d_rsp_valid", k - 1), {31'h0, rspValid}, 32'h1);
                    chk($sformatf("b2b%0d_rsp_data", k - 1),  rspData, be[k-1]);
                end
                if (k < 4) drive(1'b0, 2'b10, 1'b0, ba[k], 32'h0);
                else       idle_req();
            end
        end

        // Half store 0xBEEF to 0x002 over 0x11223344, load 0x000 right after.
        @(negedge clock);
        drive(1'b1, 2'b10, 1'b0, 10'h000, 32'h11223344);
        @(negedge clock);
        drive(1'b1, 2'b01, 1'b0, 10'h002, 32'h0000BEEF);
        @(negedge clock);
        drive(1'b0, 2'b10, 1'b0, 10'h000, 32'h0);
        #1;
        chk("hs_merge_ready", {31'h0, reqReady},       32'h0);
        chk("hs_merge_wr_en", {31'h0, memWriteEnable}, 32'h1);
        chk("hs_merge_data",  memWriteData,            32'hBEEF3344);
        @(negedge clock);
        #1;
        chk("hs_rsp_valid",  {31'h0, rspValid}, 32'h1);
        chk("hs_rsp_data",   rspData,           32'h0);
        chk("hs_load_ready", {31'h0, reqReady}, 32'h1);
        @(negedge clock);
        idle_req();
        #1;
        chk("hs_load_valid", {31'h0, rspValid}, 32'h1);
        chk("hs_load_data",  rspData,           32'hBEEF3344);

        // Reset asserted in MERGE: write dropped, no response.
        @(negedge clock);
        drive(1'b1, 2'b10, 1'b0, 10'h00C, 32'h55667788);
        @(negedge clock);
        drive(1'b1, 2'b01, 1'b0, 10'h00C, 32'h00001234);
        @(negedge clock);
        idle_req();
        reset = 1'b1;
        #1;
        chk("rm_wr_en", {31'h0, memWriteEnable}, 32'h0);
        chk("rm_ready", {31'h0, reqReady},       32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rm_rsp_valid", {31'h0, rspValid}, 32'h0);
        chk("rm_ready_post",{31'h0, reqReady}, 32'h1);
        drive(1'b0, 2'b10, 1'b0, 10'h00C, 32'h0);
        @(negedge clock);
        idle_req();
        #1;
        chk("rm_mem_valid", {31'h0, rspValid}, 32'h1);
        chk("rm_mem_data",  rspData,           32'h55667788);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsram_access_unit.md
# bsram_access_unit

Initiator-side access unit for a word-wide `BSRAM`. It accepts byte, halfword and word load/store requests from the core's memory stage over a valid/ready handshake and drives the `BSRAM` read and write ports. Loads return lane-extracted, sign- or zero-extended data. Sub-word stores become a two-cycle read-modify-write. It sits between the core's memory stage and a data `BSRAM` instance, whose read is same-cycle.

## Interface
Parameters:
- `CORE`, 0, core index, used only in report output
- `DATA_WIDTH`, 32, word width; only 32 is supported
- `ADDR_WIDTH`, 8, `BSRAM` word-address width; request addresses are byte addresses of `ADDR_WIDTH+2` bits

Ports:
- `clock`  in  1  sole clock; every register updates on posedge
- `reset`  in  1  synchronous, active-high
- `reqValid`  in  1  request present
- `reqReady`  out  1  unit can accept a request this cycle
- `reqWrite`  in  1  1 = store, 0 = load
- `reqSize`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `reqSigned`  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- `reqAddress`  in  ADDR_WIDTH+2  byte address
- `reqWriteData`  in  32  store data, right-aligned
- `rspValid`  out  1  one-cycle response pulse; no backpressure
- `rspData`  out  32  load result; 0 for stores and errors
- `rspError`  out  1  misaligned or illegal-size request
- `memReadEnable`  out  1  to `BSRAM` readEnable
- `memReadAddress`  out  ADDR_WIDTH  word address
- `memReadData`  in  32  from `BSRAM` readData, valid in the same cycle
- `memWriteEnable`  out  1  to `BSRAM` writeEnable
- `memWriteAddress`  out  ADDR_WIDTH  word address
- `memWriteData`  out  32  full word to write
- `report`  in  1  when high, print a per-cycle state, request and response summary tagged with `CORE` and a cycle count

## Operation
- Word address is `reqAddress[ADDR_WIDTH+1:2]`. Lane is `reqAddress[1:0]`.
- Two states, IDLE and MERGE.
- **IDLE** (`reqReady`=1). Accept when `reqValid`=1:
  - Error request: `reqSize`=11, half with `addr[0]`=1, or word with `addr[1:0]`≠0. No memory enable is asserted. The response carries `rspError`=1 and `rspData`=0.
  - Load: `memReadEnable`=1 combinationally in the accept cycle. Lane data is extracted and extended, then registered into `rspData`.
    - Byte: `word[8*lane +: 8]`.
    - Half: `word[16*addr[1] +: 16]`.
    - Word: returned unchanged, `reqSigned` ignored.
    - Stay in IDLE.
  - Word store: `memWriteEnable`=1 in the accept cycle with `reqWriteData`. Stay in IDLE.
  - Sub-word store:
    - Accept cycle: `memReadEnable`=1; latch word address, lane, size, store data and `memReadData`.
    - Go to MERGE.
- **MERGE** (`reqReady`=0, `memReadEnable`=0):
  - `memWriteEnable`=1 at the latched address.
  - `memWriteData` = latched word with the byte lane replaced by `data[7:0]`, or the half lane replaced by `data[15:0]`.
  - Go to IDLE.
- Response for stores: `rspData`=0, `rspError`=0.
- While `reset`=1: `reqReady`, `memReadEnable` and `memWriteEnable` are all forced to 0.
- Reset values: state IDLE; `rspValid`, `rspData`, `rspError` and all latches 0.
- Reset asserted in MERGE: the pending write is dropped, no response is issued, memory is unchanged.
- Unused memory address and data outputs drive 0.

## Timing
- Load, word store, error: accepted at cycle N; `rspValid` pulses at N+1.
- Sub-word store: accepted at N; read at N; write at N+1; `rspValid` at N+2; `reqReady`=0 during N+1.
- Peak throughput is one request per cycle. Back-to-back loads and word stores give continuous `rspValid`.
- A load accepted at N+2 after a sub-word store sees the merged word, because the write commits at the N+1 edge.
- A load following a word store in the next cycle sees the stored word.
- `rspValid` is 0 in any cycle without a response due.

## Test plan
- Word store and word load:
  - Stimulus: after reset, word store 0xDEADBEEF to byte address 0x010, then word load from 0x010.
  - Required: `memWriteAddress`=0x04; load `rspData`=0xDEADBEEF, `rspError`=0.
- Byte store read-modify-write:
  - Stimulus: memory word 1 = 0x11223344; byte store 0xA5 to address 0x005.
  - Required: `reqReady` low for one cycle; `memWriteData`=0x1122A544; `rspValid` two cycles after accept.
- Sign and zero extension, with word 0 = 0x80FF0000:
  - Signed byte load at 0x003 returns 0xFFFFFF80.
  - Unsigned byte load at 0x003 returns 0x00000080.
  - Signed half load at 0x002 returns 0xFFFF80FF.
  - Unsigned half load at 0x000 returns 0x00000000.
- Error requests:
  - Stimulus: half load at 0x001, word store at 0x002, `reqSize`=11.
  - Required: each gives `rspError`=1 and `rspData`=0 at N+1, with no mem enables asserted.
- Back-to-back traffic:
  - Stimulus: loads on four consecutive cycles; then a half store of 0xBEEF to 0x002 over 0x11223344, immediately followed by a load of 0x000.
  - Required: `rspValid` high for four consecutive cycles; the load returns 0xBEEF3344.
- Reset during MERGE:
  - Stimulus: assert `reset` during MERGE.
  - Required: no `memWriteEnable`, no `rspValid`, memory unchanged; `reqReady`=1 in the first cycle after `reset` drops.
